truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning the number of cycles each input combination is held before s_in is sampled (legal range 1..15).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a scan; sampled only in IDLE.
REQ-005 expected  input  8  expected truth table, bit i = f(idx i); latched when start is accepted.
REQ-006 s_in  input  1  output of the combinational function under test.
REQ-007 x, y, z  output  1 each  stimulus to the function under test; {x,y,z} = idx, with x as MSB.
REQ-008 busy  output  1  high while a scan is in progress.
REQ-009 done  output  1  one-cycle pulse marking scan completion.
REQ-010 table_out  output  8  captured truth table, bit i = s_in sampled for idx i.
REQ-011 mismatch  output  8  table_out XOR latched expected.
REQ-012 pass  output  1  high when mismatch == 8'h00.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE; all outputs SHALL be registered.
REQ-014 IDLE: when start=1 at an edge, the block SHALL latch expected, set idx=0, clear table_out, mismatch and pass, set busy=1, and go to DRIVE.
REQ-015 DRIVE: the block SHALL hold {x,y,z}=idx for SETTLE edges (settle counter), then go to SAMPLE.
REQ-016 SAMPLE: on that edge the block SHALL write s_in into table_out[idx]; if idx=7 it SHALL go to DONE, else it SHALL increment idx and return to DRIVE.
REQ-017 Each combination SHALL occupy exactly SETTLE+1 cycles; s_in SHALL be ignored in every cycle except the SAMPLE cycle.
REQ-018 Entering DONE, the block SHALL update mismatch and pass from the final table; done SHALL be high only while in DONE, which is exactly one cycle.
REQ-019 From DONE the block SHALL return to IDLE on the next edge, with busy=0 and {x,y,z}=000.
REQ-020 Latency: done SHALL be high in the cycle following edge number 8*(SETTLE+1), counted from the edge that accepted start (SETTLE=1 gives 16).
REQ-021 table_out, mismatch and pass SHALL hold their values until the next accepted start.
REQ-022 start SHALL be ignored in DRIVE, SAMPLE and DONE; it is not queued.
REQ-023 The block SHALL latch expected only at start acceptance; later changes to expected SHALL NOT affect mismatch or pass.
REQ-024 idx SHALL be 3 bits and SHALL NOT wrap during a scan; the scan SHALL terminate after idx 7.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, idx=0, x=y=z=0, busy=0, done=0, table_out=8'h00, mismatch=8'h00, pass=0, and clear the settle counter.
REQ-026 A reset during a scan SHALL abort it with no done pulse; the next accepted start SHALL rescan from idx 0.

Verification
REQ-027 Reset: assert rst_n=0 mid-cycle -> all outputs are 0 immediately, without waiting for a clock edge.
REQ-028 Nominal scan: SETTLE=1, s_in = (x|y)|(x&~y), expected=8'hFC, one-cycle start -> {x,y,z} steps 000..111, each held 2 cycles; done pulses after 16 edges; table_out=8'hFC, mismatch=8'h00, pass=1.
REQ-029 Wrong expectation: same as REQ-028 but expected=8'hFE -> table_out=8'hFC, mismatch=8'h02, pass=0.
REQ-030 Busy start: start pulsed again at idx 3, and expected changed to 8'h00 mid-scan -> the sequence is unchanged; exactly one done pulse; pass=1.
REQ-031 Abort: rst_n pulsed low while idx=4 -> outputs clear with no done pulse; a new start gives a full 000..111 scan with the correct table.
REQ-032 Settle: SETTLE=3 and s_in forced to 1 in all non-SAMPLE cycles, otherwise 0 -> done after 32 edges; table_out=8'h00.

Source files
------------

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks a 3-input stimulus through all 8 combinations,
// samples the function under test once per combination and compares the
// captured table against a latched expectation.
module truth_table_scanner #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       s_in,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic [7:0] mismatch,
    output logic       pass
);

    localparam int unsigned IW = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned TW = 8;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] settle_q;
    logic [TW-1:0] exp_q;
    logic [TW-1:0] table_q;
    logic [TW-1:0] table_d;
    logic [TW-1:0] mismatch_q;
    logic          pass_q;
    logic          busy_q;
    logic          done_q;

    // Captured table with the current sample folded in.
    always_comb begin
        table_d        = table_q;
        table_d[idx_q] = s_in;
    end

    // Scan sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            settle_q   <= '0;
            exp_q      <= '0;
            table_q    <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        exp_q      <= expected;
                        idx_q      <= '0;
                        settle_q   <= '0;
                        table_q    <= '0;
                        mismatch_q <= '0;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= '0;
                        state_q  <= S_SAMPLE;
                    end else begin
                        settle_q <= settle_q + CW'(1);
                    end
                end
                S_SAMPLE: begin
                    table_q <= table_d;
                    if (idx_q == IDX_LAST) begin
                        // Final comparison is made from the table including this sample.
                        mismatch_q <= table_d ^ exp_q;
                        pass_q     <= ((table_d ^ exp_q) == '0);
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        state_q <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign x         = idx_q[2];
    assign y         = idx_q[1];
    assign z         = idx_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign mismatch  = mismatch_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: one instance with SETTLE=1 driven
// by f = (x|y)|(x&~y), one with SETTLE=3 driven by a bench-controlled s_in.
module tb_truth_table_scanner;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start_a, start_b;
    logic [7:0] expected_a, expected_b;
    logic       s_in_a, s_in_b;
    logic       x_a, y_a, z_a, busy_a, done_a, pass_a;
    logic       x_b, y_b, z_b, busy_b, done_b, pass_b;
    logic [7:0] table_a, mismatch_a, table_b, mismatch_b;

    int checks = 0;
    int errors = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    always #5 clk = ~clk;

    // Function under test for instance A.
    assign s_in_a = (x_a | y_a) | (x_a & ~y_a);

    truth_table_scanner #(.SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(expected_a),
        .s_in(s_in_a), .x(x_a), .y(y_a), .z(z_a), .busy(busy_a), .done(done_a),
        .table_out(table_a), .mismatch(mismatch_a), .pass(pass_a)
    );

    truth_table_scanner #(.SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(expected_b),
        .s_in(s_in_b), .x(x_b), .y(y_b), .z(z_b), .busy(busy_b), .done(done_b),
        .table_out(table_b), .mismatch(mismatch_b), .pass(pass_b)
    );

    // Count done pulses as seen at each rising edge.
    always @(posedge clk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Full scan on instance A with per-cycle stimulus checks.
    task automatic scan_a(input string nm, input logic [7:0] exp_v, input logic [7:0] tbl,
                          input logic [7:0] mm, input logic ps, input bit poke);
        int dc0;
        dc0 = done_cnt_a;
        expected_a = exp_v;
        start_a    = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (poke && k == 6) begin
                start_a    = 1'b1;
                expected_a = 8'h00;
            end
            if (poke && k == 7) start_a = 1'b0;
            chk({nm, " xyz"}, 32'({x_a, y_a, z_a}), 32'(k / 2));
            chk({nm, " busy"}, 32'(busy_a), 32'd1);
            chk({nm, " done early"}, 32'(done_a), 32'd0);
            @(negedge clk);
        end
        chk({nm, " done"}, 32'(done_a), 32'd1);
        chk({nm, " table"}, 32'(table_a), 32'(tbl));
        chk({nm, " mismatch"}, 32'(mismatch_a), 32'(mm));
        chk({nm, " pass"}, 32'(pass_a), 32'(ps));
        @(negedge clk);
        chk({nm, " done clr"}, 32'(done_a), 32'd0);
        chk({nm, " busy clr"}, 32'(busy_a), 32'd0);
        chk({nm, " xyz idle"}, 32'({x_a, y_a, z_a}), 32'd0);
        chk({nm, " table hold"}, 32'(table_a), 32'(tbl));
        chk({nm, " pass hold"}, 32'(pass_a), 32'(ps));
        @(negedge clk);
        chk({nm, " done count"}, 32'(done_cnt_a - dc0), 32'd1);
    endtask

    initial begin
        int dc0;
        rst_n      = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        expected_a = 8'h00;
        expected_b = 8'h00;
        s_in_b     = 1'b1;
        #12;
        chk("reset A outs", 32'({x_a, y_a, z_a, busy_a, done_a, pass_a}), 32'd0);
        chk("reset A table", 32'({table_a, mismatch_a}), 32'd0);
        chk("reset B outs", 32'({x_b, y_b, z_b, busy_b, done_b, pass_b}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal scan.
        scan_a("nominal", 8'hFC, 8'hFC, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset clears held results mid-cycle.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst outs", 32'({x_a, y_a, z_a, busy_a, done_a, pass_a}), 32'd0);
        chk("async rst table", 32'({table_a, mismatch_a}), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Wrong expectation.
        scan_a("wrongexp", 8'hFE, 8'hFC, 8'h02, 1'b0, 1'b0);

        // Start pulsed and expectation changed while busy.
        scan_a("busystart", 8'hFC, 8'hFC, 8'h00, 1'b1, 1'b1);

        // Abort at idx 4.
        dc0        = done_cnt_a;
        expected_a = 8'hFC;
        start_a    = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort at idx4", 32'({x_a, y_a, z_a}), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort outs", 32'({x_a, y_a, z_a, busy_a, done_a, pass_a}), 32'd0);
        chk("abort table", 32'({table_a, mismatch_a}), 32'd0);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort no done", 32'(done_cnt_a - dc0), 32'd0);
        chk("abort idle busy", 32'(busy_a), 32'd0);
        scan_a("rescan", 8'hFC, 8'hFC, 8'h00, 1'b1, 1'b0);

        // SETTLE=3: s_in is 1 everywhere except the sampling cycle.
        dc0        = done_cnt_b;
        expected_b = 8'h5A;
        start_b    = 1'b1;
        s_in_b     = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 32; k++) begin
            s_in_b = ((k % 4) == 3) ? 1'b0 : 1'b1;
            chk("settle xyz", 32'({x_b, y_b, z_b}), 32'(k / 4));
            chk("settle done early", 32'(done_b), 32'd0);
            @(negedge clk);
        end
        s_in_b = 1'b1;
        chk("settle done", 32'(done_b), 32'd1);
        chk("settle table", 32'(table_b), 32'h00);
        chk("settle mismatch", 32'(mismatch_b), 32'h5A);
        chk("settle pass", 32'(pass_b), 32'd0);
        @(negedge clk);
        chk("settle busy clr", 32'(busy_b), 32'd0);
        @(negedge clk);
        chk("settle done count", 32'(done_cnt_b - dc0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
